// File: rtl/xr16_dmac_pkg.sv
// xr16_dmac_pkg: shared definitions for the xr16 multi-channel DMA controller.
//   - configuration register select encodings
//   - control word bit positions (write view and read-back view)
//   - controller FSM state type
package xr16_dmac_pkg;

    // cfg_sel encodings
    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_LEN  = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // ctrl bit positions; CLR is write-only, DONE is read-only and reuses bit 3
    localparam int EN   = 0;
    localparam int RING = 1;
    localparam int WORD = 2;
    localparam int CLR  = 3;
    localparam int DONE = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/xr16_rr_arb.sv
// xr16_rr_arb: combinational round-robin arbiter.
//   req  in  CH           request vector
//   last in  $clog2(CH)   index of the last-served channel
//   gnt  out CH           one-hot grant; search starts at last+1, wraps at CH
module xr16_rr_arb #(
    parameter int CH = 4
) (
    input  logic [CH-1:0]         req,
    input  logic [$clog2(CH)-1:0] last,
    output logic [CH-1:0]         gnt
);
    localparam int CHW = $clog2(CH);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        // last itself is visited last, so a lone requester can still win
        for (int i = 1; i <= CH; i++) begin
            idx = int'(last) + i;
            if (idx >= CH) idx = idx - CH;
            if (!found && req[CHW'(idx)]) begin
                gnt[CHW'(idx)] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xr16_dmac.sv
// xr16_dmac: multi-channel DMA controller for the xr16 memory interface.
//   ch_req   in  CH   per-channel level request
//   dma_ack  in  1    xr16 granted current access as DMA
//   rdy      in  1    memory access ready
//   cfg_we/cfg_ch/cfg_sel/cfg_d  in   configuration write port
//   cfg_q    out W    combinational read-back of selected register
//   dma_req/dma_addr/dma_word    out  registered transfer request
//   ch_gnt   out CH   one-hot channel in service
//   ch_done  out CH   one-cycle pulse on a channel's last transfer
//   irq      out 1    registered OR of sticky done bits
module xr16_dmac
    import xr16_dmac_pkg::*;
#(
    parameter int W  = 16,
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         ch_req,
    input  logic                  dma_ack,
    input  logic                  rdy,
    input  logic                  cfg_we,
    input  logic [$clog2(CH)-1:0] cfg_ch,
    input  logic [1:0]            cfg_sel,
    input  logic [W-1:0]          cfg_d,
    output logic [W-1:0]          cfg_q,
    output logic                  dma_req,
    output logic [W-1:0]          dma_addr,
    output logic                  dma_word,
    output logic [CH-1:0]         ch_gnt,
    output logic [CH-1:0]         ch_done,
    output logic                  irq
);
    localparam int CHW = $clog2(CH);

    logic [CH-1:0][W-1:0]  base, cur;
    logic [CH-1:0][CW-1:0] len, rem;
    logic [CH-1:0]         en, ring, word, done;

    state_t         state;
    logic [CHW-1:0] ptr;   // last-served channel
    logic [CHW-1:0] gidx;  // channel in service
    logic [CH-1:0]  elig, gnt;
    logic [CHW-1:0] gsel;

    always_comb begin
        for (int i = 0; i < CH; i++)
            elig[i] = ch_req[i] & en[i] & (rem[i] != '0);
    end

    xr16_rr_arb #(.CH(CH)) u_arb (
        .req  (elig),
        .last (ptr),
        .gnt  (gnt)
    );

    always_comb begin
        gsel = '0;
        for (int i = 0; i < CH; i++)
            if (gnt[i]) gsel = CHW'(i);
    end

    logic [3:0] ctrl_rb;
    always_comb begin
        ctrl_rb       = '0;
        ctrl_rb[EN]   = en[cfg_ch];
        ctrl_rb[RING] = ring[cfg_ch];
        ctrl_rb[WORD] = word[cfg_ch];
        ctrl_rb[DONE] = done[cfg_ch];
        cfg_q         = '0;
        case (cfg_sel)
            SEL_BASE: cfg_q = cur[cfg_ch];
            SEL_LEN:  cfg_q = W'(rem[cfg_ch]);
            SEL_CTRL: cfg_q = W'(ctrl_rb);
            default:  cfg_q = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= CHW'(CH - 1);
            gidx     <= '0;
            dma_req  <= 1'b0;
            dma_addr <= '0;
            dma_word <= 1'b0;
            ch_gnt   <= '0;
            ch_done  <= '0;
            irq      <= 1'b0;
            base     <= '0;
            cur      <= '0;
            len      <= '0;
            rem      <= '0;
            en       <= '0;
            ring     <= '0;
            word     <= '0;
            done     <= '0;
        end else begin
            ch_done <= '0;
            irq     <= |done;
            case (state)
                IDLE: begin
                    if (|elig) begin
                        gidx     <= gsel;
                        dma_addr <= cur[gsel];
                        dma_word <= word[gsel];
                        ch_gnt   <= gnt;
                        dma_req  <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // runs to completion regardless of ch_req/en changes
                    if (dma_ack && rdy) begin
                        cur[gidx] <= dma_addr + (dma_word ? W'(2) : W'(1));
                        rem[gidx] <= rem[gidx] - CW'(1);
                        if (rem[gidx] == CW'(1)) begin
                            ch_done[gidx] <= 1'b1;
                            done[gidx]    <= 1'b1;
                            if (ring[gidx]) begin
                                cur[gidx] <= base[gidx];
                                rem[gidx] <= len[gidx];
                            end else begin
                                en[gidx] <= 1'b0;
                            end
                        end
                        ptr     <= gidx;
                        dma_req <= 1'b0;
                        ch_gnt  <= '0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // after the completion update so a same-cycle write takes priority
            if (cfg_we) begin
                case (cfg_sel)
                    SEL_BASE: begin
                        base[cfg_ch] <= cfg_d;
                        cur[cfg_ch]  <= cfg_d;
                    end
                    SEL_LEN: begin
                        len[cfg_ch] <= cfg_d[CW-1:0];
                        rem[cfg_ch] <= cfg_d[CW-1:0];
                    end
                    SEL_CTRL: begin
                        en[cfg_ch]   <= cfg_d[EN];
                        ring[cfg_ch] <= cfg_d[RING];
                        word[cfg_ch] <= cfg_d[WORD];
                        if (cfg_d[CLR]) done[cfg_ch] <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xr16_dmac.sv
module tb_xr16_dmac;
    localparam int W = 16, CH = 4, CW = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [CH-1:0] ch_req = '0;
    logic          dma_ack = 1'b0, rdy = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0, cfg_sel = '0;
    logic [W-1:0]  cfg_d = '0;
    logic [W-1:0]  cfg_q, dma_addr;
    logic          dma_req, dma_word, irq;
    logic [CH-1:0] ch_gnt, ch_done;

    xr16_dmac #(.W(W), .CH(CH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .dma_ack(dma_ack), .rdy(rdy),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_d(cfg_d),
        .cfg_q(cfg_q), .dma_req(dma_req), .dma_addr(dma_addr), .dma_word(dma_word),
        .ch_gnt(ch_gnt), .ch_done(ch_done), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  addr;
        logic [CH-1:0] gnt;
        logic          word;
    } xfer_t;

    xfer_t         xq[$];
    logic [CH-1:0] dq[$];
    int            n_run = 0, n_fail = 0;
    logic          auto_ack = 1'b1, rdy_block = 1'b0;
    logic          req_q;
    xfer_t         e;
    logic [CH-1:0] de;
    logic [W-1:0]  rv;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic exp_x(input logic [W-1:0] a, input logic [CH-1:0] g, input logic wd);
        xfer_t t;
        t.addr = a; t.gnt = g; t.word = wd;
        xq.push_back(t);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ch_req = '0; cfg_we = 1'b0; rdy_block = 1'b0;
        xq.delete(); dq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic cfg(input int c, input logic [1:0] s, input logic [W-1:0] d);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_sel = s; cfg_d = d;
        @(posedge clk); #1 cfg_we = 1'b0;
    endtask

    task automatic rd(input int c, input logic [1:0] s, output logic [W-1:0] q);
        cfg_ch = 2'(c); cfg_sel = s;
        #1 q = cfg_q;
    endtask

    task automatic setup(input int c, input logic [W-1:0] b, input logic [W-1:0] l,
                         input logic [W-1:0] ctl);
        cfg(c, 2'd0, b); cfg(c, 2'd1, l); cfg(c, 2'd2, ctl);
    endtask

    // wait for every expected transfer, drop requests, then let pulses settle
    task automatic run(input string tag, input int maxc);
        int c;
        c = 0;
        while (xq.size() != 0 && c < maxc) begin
            @(posedge clk); #1; c++;
        end
        ch_req = '0;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_xq"}, xq.size(), 0);
        chk({tag, "_dq"}, dq.size(), 0);
    endtask

    task automatic wait_req(input string tag);
        int c;
        c = 0;
        while (!dma_req && c < 50) begin
            @(posedge clk); #1; c++;
        end
        chk({tag, "_req"}, dma_req, 1);
    endtask

    // memory-side responder: ack one cycle after dma_req, rdy unless blocked
    initial forever begin
        @(posedge clk); #1;
        dma_ack = auto_ack & dma_req;
        rdy     = dma_ack & ~rdy_block;
    end

    // scoreboard monitor
    initial begin
        req_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) req_q = 1'b0;
            else begin
                if (dma_req && !req_q) begin
                    if (xq.size() == 0) chk("unexp_gnt", 32'(ch_gnt), 0);
                    else begin
                        e = xq.pop_front();
                        chk("addr", 32'(dma_addr), 32'(e.addr));
                        chk("gnt", 32'(ch_gnt), 32'(e.gnt));
                        chk("word", 32'(dma_word), 32'(e.word));
                    end
                end
                if (ch_done != '0) begin
                    if (dq.size() == 0) chk("unexp_done", 32'(ch_done), 0);
                    else begin
                        de = dq.pop_front();
                        chk("done", 32'(ch_done), 32'(de));
                    end
                end
                req_q = dma_req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_req", dma_req, 0);
        chk("rst_addr", dma_addr, 0);
        chk("rst_word", dma_word, 0);
        chk("rst_gnt", ch_gnt, 0);
        chk("rst_done", ch_done, 0);
        chk("rst_irq", irq, 0);
        rd(1, 2'd0, rv); chk("rst_cur", rv, 0);
        rd(2, 2'd1, rv); chk("rst_rem", rv, 0);
        rd(3, 2'd2, rv); chk("rst_ctl", rv, 0);
        @(posedge clk); #1;

        // ch0 byte mode, three transfers
        setup(0, 16'h1000, 16'd3, 16'h0001);
        exp_x(16'h1000, 4'b0001, 1'b0);
        exp_x(16'h1001, 4'b0001, 1'b0);
        exp_x(16'h1002, 4'b0001, 1'b0);
        dq.push_back(4'b0001);
        ch_req = 4'b0001;
        @(negedge clk); chk("lat0", dma_req, 0);
        @(negedge clk); chk("lat1", dma_req, 1);
        run("t1", 60);
        rd(0, 2'd2, rv); chk("t1_ctl", rv, 16'h0008);
        rd(0, 2'd1, rv); chk("t1_rem", rv, 0);
        rd(0, 2'd0, rv); chk("t1_cur", rv, 16'h1003);
        chk("t1_irq", irq, 1);
        cfg(0, 2'd2, 16'h0008);
        repeat (2) @(posedge clk); #1;
        rd(0, 2'd2, rv); chk("clr_ctl", rv, 0);
        chk("clr_irq", irq, 0);

        // ch1 word mode wrapping past 0xFFFF
        do_reset();
        setup(1, 16'hFFFE, 16'd2, 16'h0005);
        exp_x(16'hFFFE, 4'b0010, 1'b1);
        exp_x(16'h0000, 4'b0010, 1'b1);
        dq.push_back(4'b0010);
        ch_req = 4'b0010;
        run("t2", 60);
        rd(1, 2'd0, rv); chk("t2_cur", rv, 16'h0002);
        rd(1, 2'd2, rv); chk("t2_ctl", rv, 16'h000C);

        // ch2 ring mode
        do_reset();
        setup(2, 16'h0020, 16'd2, 16'h0003);
        for (int k = 0; k < 3; k++) begin
            exp_x(16'h0020, 4'b0100, 1'b0);
            exp_x(16'h0021, 4'b0100, 1'b0);
            dq.push_back(4'b0100);
        end
        ch_req = 4'b0100;
        run("t3", 100);
        rd(2, 2'd2, rv); chk("t3_ctl", rv, 16'h000B);
        rd(2, 2'd1, rv); chk("t3_rem", rv, 2);
        rd(2, 2'd0, rv); chk("t3_cur", rv, 16'h0020);

        // round-robin rotation with all channels requesting
        do_reset();
        for (int c = 0; c < CH; c++) setup(c, 16'((c + 1) * 256), 16'd8, 16'h0001);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < CH; c++)
                exp_x(16'((c + 1) * 256 + k), 4'(1 << c), 1'b0);
        ch_req = 4'b1111;
        run("t4", 120);

        // rdy stall, en cleared mid-wait
        do_reset();
        setup(0, 16'h0500, 16'd4, 16'h0001);
        exp_x(16'h0500, 4'b0001, 1'b0);
        rdy_block = 1'b1;
        ch_req = 4'b0001;
        wait_req("t5");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) cfg(0, 2'd2, 16'h0000);
            else begin @(posedge clk); #1; end
            chk("t5_hold_req", dma_req, 1);
            chk("t5_hold_addr", dma_addr, 16'h0500);
        end
        rdy_block = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_idle", dma_req, 0);
        rd(0, 2'd1, rv); chk("t5_rem", rv, 3);
        rd(0, 2'd0, rv); chk("t5_cur", rv, 16'h0501);
        ch_req = '0;
        chk("t5_xq", xq.size(), 0);

        // reset mid-BUSY
        do_reset();
        setup(0, 16'h0700, 16'd2, 16'h0001);
        exp_x(16'h0700, 4'b0001, 1'b0);
        rdy_block = 1'b1;
        ch_req = 4'b0001;
        wait_req("t6");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_req", dma_req, 0);
        chk("t6_addr", dma_addr, 0);
        chk("t6_gnt", ch_gnt, 0);
        do_reset();
        setup(0, 16'h0800, 16'd1, 16'h0001);
        setup(1, 16'h0900, 16'd1, 16'h0001);
        exp_x(16'h0800, 4'b0001, 1'b0);
        exp_x(16'h0900, 4'b0010, 1'b0);
        dq.push_back(4'b0001);
        dq.push_back(4'b0010);
        ch_req = 4'b0011;
        run("t6b", 60);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
